parking_occupancy: RTL and testbench
====================================

# parking_occupancy

Occupancy tracker that sits directly downstream of the parking gate controller. It consumes the gate's car-entered and car-exited indications and keeps a saturating count of free bays. It returns an entry permit to the gate and drives a two-digit active-low seven-segment display of free bays, or the word "FU" when the lot is full.

## Interface
Parameters:
- CAPACITY, 8, number of bays; legal range 1..99.
- CNT_W, 7, width of `free_slots`; must hold CAPACITY.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- car_entered  in  1  level from gate controller; high while a car completes entry.
- car_exited  in  1  level from exit sensor path; high while a car leaves.
- err_clr  in  1  synchronous clear of the sticky error flag.
- free_slots  out  CNT_W  current free-bay count.
- lot_full  out  1  high when `free_slots` == 0.
- lot_empty  out  1  high when `free_slots` == CAPACITY.
- entry_allow  out  1  permit to gate; equals !lot_full.
- err  out  1  sticky overflow/underflow flag.
- hex_1  out  7  tens digit, active-low, gfedcba.
- hex_2  out  7  ones digit, active-low, gfedcba.

## Operation
- Event detection:
  - A registered copy of each input gives a rising-edge pulse: `in_ev = car_entered & !car_entered_q`; `out_ev` is formed the same way from `car_exited`.
  - A level held high counts exactly once.
- Count update, applied at the same edge the event is detected:
  - in_ev only, free_slots > 0: decrement.
  - in_ev only, free_slots == 0: count holds; overflow is recorded.
  - out_ev only, free_slots < CAPACITY: increment.
  - out_ev only, free_slots == CAPACITY: count holds; underflow is recorded.
  - in_ev and out_ev together: count holds; no error is recorded, even at 0 or CAPACITY.
- Display FSM, states SHOW_CNT and SHOW_FULL:
  - SHOW_CNT -> SHOW_FULL when the next free_slots == 0.
  - SHOW_FULL -> SHOW_CNT when the next free_slots > 0.
  - SHOW_CNT: hex_1 and hex_2 show the decimal tens and ones of free_slots. The tens digit shows blank (1111111) when it is 0.
  - SHOW_FULL: hex_1 = F (0001110), hex_2 = U (1000001).
- Digit encodings:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Count arithmetic is unsigned. No wrap-around is permitted in either direction.

## Timing
- Reset values:
  - free_slots = CAPACITY.
  - lot_full = 0, lot_empty = 1, entry_allow = 1, err = 0.
  - Edge registers = 0; FSM = SHOW_CNT.
  - hex_1 = blank (or tens of CAPACITY if ≥10); hex_2 = ones of CAPACITY.
- Latency:
  - An input rising at edge n produces an updated free_slots, lot_full, lot_empty and entry_allow after edge n. These four outputs are registered.
  - hex_1 and hex_2 are registered from the FSM and count: one further cycle, valid after edge n+1.
- entry_allow deasserts in the same cycle lot_full asserts. The gate must not admit on the cycle after the last bay is taken.
- err_clr is sampled on the clock edge. If err_clr and a new error occur on the same edge, the error wins and err stays 1.
- Reset asserted mid-operation returns all state to the reset values immediately, without waiting for a clock. Edge history is cleared, so an input held high through reset release counts as a new event on the first edge.

## Configuration
- `PARKING_OCC_ERR_EN` defined:
  - err sets on overflow or underflow and stays set until err_clr or reset.
  - In SHOW_CNT with err = 1, hex_1 shows E (0000110) in place of the tens digit.
- `PARKING_OCC_ERR_EN` undefined:
  - err is tied to 0 and err_clr is ignored.
  - Overflow and underflow attempts are silently dropped; count behaviour is unchanged.

## Test plan
- Reset, then release with CAPACITY=8 -> free_slots=8, lot_empty=1, entry_allow=1, hex_1=1111111, hex_2=0000000.
- Three car_entered pulses, one held high for 5 cycles -> free_slots=5, with no extra decrement from the held level; hex_2=0010010 one cycle after the count.
- Eight entries -> free_slots=0, lot_full=1, entry_allow=0, display FU. A ninth entry -> count stays 0; err=1 when `PARKING_OCC_ERR_EN` is defined, else err=0.
- car_entered and car_exited rising on the same edge at free_slots=0 -> count stays 0, err stays 0. A following exit alone -> free_slots=1 and the display returns to digits.
- At free_slots=8, a car_exited pulse -> count stays 8. With `PARKING_OCC_ERR_EN` defined: err=1 and hex_1=0000110; pulsing err_clr -> err=0 on the next edge.
- Reset asserted asynchronously mid-count at free_slots=3 -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/parking_occupancy.sv
// Free-bay tracker: edge-detected entry/exit events drive a saturating count,
// a permit to the gate and a two-digit seven-segment display. Error flag: PARKING_OCC_ERR_EN.
module parking_occupancy #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_entered,
    input  logic             car_exited,
    input  logic             err_clr,
    output logic [CNT_W-1:0] free_slots,
    output logic             lot_full,
    output logic             lot_empty,
    output logic             entry_allow,
    output logic             err,
    output logic [6:0]       hex_1,
    output logic [6:0]       hex_2
);

    typedef enum logic {SHOW_CNT, SHOW_FULL} disp_e;

    localparam logic [CNT_W-1:0] CAP   = CNT_W'(CAPACITY);
    localparam logic [6:0]       BLANK = 7'b1111111;
    localparam logic [6:0]       SEG_F = 7'b0001110;
    localparam logic [6:0]       SEG_U = 7'b1000001;
    localparam logic [6:0]       SEG_E = 7'b0000110;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = BLANK;
        endcase
    endfunction

    localparam logic [6:0] RST_HEX1 = (CAPACITY >= 10) ? seg7(4'(CAPACITY / 10)) : BLANK;
    localparam logic [6:0] RST_HEX2 = seg7(4'(CAPACITY % 10));

    logic             car_entered_q, car_exited_q;
    logic [CNT_W-1:0] free_q, free_d;
    logic             full_q, full_d, empty_q, empty_d, allow_q, allow_d;
    disp_e            state_q, state_d;
    logic [6:0]       hex_1_q, hex_1_d, hex_2_q, hex_2_d;
    logic             in_ev, out_ev, ovf, unf, err_q;
    logic [3:0]       tens, ones;

    always_comb begin
        in_ev  = car_entered & ~car_entered_q;
        out_ev = car_exited & ~car_exited_q;
        free_d = free_q;
        ovf    = 1'b0;
        unf    = 1'b0;
        // Simultaneous entry and exit cancel, with no error even at the limits.
        if (in_ev && !out_ev) begin
            if (free_q != '0) free_d = free_q - 1'b1;
            else              ovf    = 1'b1;
        end else if (out_ev && !in_ev) begin
            if (free_q != CAP) free_d = free_q + 1'b1;
            else               unf    = 1'b1;
        end
        full_d  = (free_d == '0);
        empty_d = (free_d == CAP);
        allow_d = (free_d != '0);
        state_d = (free_d == '0) ? SHOW_FULL : SHOW_CNT;
    end

    // Display lags the count by one cycle: it is built from the registered state.
    always_comb begin
        tens = 4'(free_q / CNT_W'(10));
        ones = 4'(free_q % CNT_W'(10));
        if (state_q == SHOW_FULL) begin
            hex_1_d = SEG_F;
            hex_2_d = SEG_U;
        end else begin
            if (err_q)             hex_1_d = SEG_E;
            else if (tens == 4'd0) hex_1_d = BLANK;
            else                   hex_1_d = seg7(tens);
            hex_2_d = seg7(ones);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            car_entered_q <= 1'b0;
            car_exited_q  <= 1'b0;
            free_q        <= CAP;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            allow_q       <= 1'b1;
            state_q       <= SHOW_CNT;
            hex_1_q       <= RST_HEX1;
            hex_2_q       <= RST_HEX2;
        end else begin
            car_entered_q <= car_entered;
            car_exited_q  <= car_exited;
            free_q        <= free_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
            allow_q       <= allow_d;
            state_q       <= state_d;
            hex_1_q       <= hex_1_d;
            hex_2_q       <= hex_2_d;
        end
    end

`ifdef PARKING_OCC_ERR_EN
    logic err_d;

    always_comb begin
        err_d = err_q;
        if (err_clr)    err_d = 1'b0;
        if (ovf || unf) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`else
    logic unused_err_sig;

    assign err_q          = 1'b0;
    assign unused_err_sig = ^{err_clr, ovf, unf};
`endif

    assign free_slots  = free_q;
    assign lot_full    = full_q;
    assign lot_empty   = empty_q;
    assign entry_allow = allow_q;
    assign err         = err_q;
    assign hex_1       = hex_1_q;
    assign hex_2       = hex_2_q;

endmodule

// File: tb/tb_parking_occupancy.sv
// Scoreboard bench for parking_occupancy (CAPACITY=8): directed stimulus queues
// expected status/display snapshots, a negedge monitor compares them.
module tb_parking_occupancy;

`ifdef PARKING_OCC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D6 = 7'b0000010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SU = 7'b1000001;
    localparam logic [6:0] SE = 7'b0000110;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       car_entered = 1'b0, car_exited = 1'b0, err_clr = 1'b0;
    logic [6:0] free_slots, hex_1, hex_2;
    logic       lot_full, lot_empty, entry_allow, err;

    parking_occupancy #(.CAPACITY(8), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .car_entered(car_entered), .car_exited(car_exited),
        .err_clr(err_clr), .free_slots(free_slots), .lot_full(lot_full),
        .lot_empty(lot_empty), .entry_allow(entry_allow), .err(err),
        .hex_1(hex_1), .hex_2(hex_2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at_cyc;
        bit         kind;   // 0: status outputs, 1: display
        string      tag;
        logic [6:0] f;
        logic       full, empty, allow, e;
        logic [6:0] h1, h2;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input string tag, input logic [6:0] act, input logic [6:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %b expected %b (t=%0t)", tag, name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].at_cyc <= cyc) begin
            exp_t x;
            x = sb.pop_front();
            if (x.at_cyc < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s.stale: sampled at cycle %0d expected cycle %0d", x.tag, cyc, x.at_cyc);
            end else if (x.kind == 1'b0) begin
                chk("free_slots", x.tag, free_slots, x.f);
                chk("lot_full", x.tag, 7'(lot_full), 7'(x.full));
                chk("lot_empty", x.tag, 7'(lot_empty), 7'(x.empty));
                chk("entry_allow", x.tag, 7'(entry_allow), 7'(x.allow));
                chk("err", x.tag, 7'(err), 7'(x.e));
            end else begin
                chk("hex_1", x.tag, hex_1, x.h1);
                chk("hex_2", x.tag, hex_2, x.h2);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_st(input string tag, input logic [6:0] f, input logic full, input logic empty,
                          input logic allow, input logic e);
        exp_t x;
        x.at_cyc = cyc; x.kind = 1'b0; x.tag = tag;
        x.f = f; x.full = full; x.empty = empty; x.allow = allow; x.e = e;
        x.h1 = '0; x.h2 = '0;
        sb.push_back(x);
    endtask

    task automatic exp_hex(input string tag, input logic [6:0] h1, input logic [6:0] h2);
        exp_t x;
        x.at_cyc = cyc; x.kind = 1'b1; x.tag = tag;
        x.f = '0; x.full = 1'b0; x.empty = 1'b0; x.allow = 1'b0; x.e = 1'b0;
        x.h1 = h1; x.h2 = h2;
        sb.push_back(x);
    endtask

    task automatic enter_once();
        car_entered = 1'b1; step();
        car_entered = 1'b0; step();
    endtask

    task automatic exit_once();
        car_exited = 1'b1; step();
        car_exited = 1'b0; step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        exp_st("in_reset", 7'd8, 0, 1, 1, 0);
        exp_hex("in_reset", BLANK, D8);
        reset = 1'b1;
        step();
        exp_st("post_reset", 7'd8, 0, 1, 1, 0);
        exp_hex("post_reset", BLANK, D8);

        // two single pulses
        car_entered = 1'b1; step(); exp_st("ent1", 7'd7, 0, 0, 1, 0);
        car_entered = 1'b0; step(); exp_hex("ent1", BLANK, D7);
        car_entered = 1'b1; step(); exp_st("ent2", 7'd6, 0, 0, 1, 0);
        car_entered = 1'b0; step(); exp_hex("ent2", BLANK, D6);

        // level held five cycles counts once
        car_entered = 1'b1; step(); exp_st("held_a", 7'd5, 0, 0, 1, 0);
        step(); exp_st("held_b", 7'd5, 0, 0, 1, 0); exp_hex("held_b", BLANK, D5);
        step(); step(); step(); exp_st("held_c", 7'd5, 0, 0, 1, 0);
        car_entered = 1'b0; step(); exp_st("held_d", 7'd5, 0, 0, 1, 0);

        // fill the lot
        repeat (4) enter_once();
        car_entered = 1'b1; step(); exp_st("full", 7'd0, 1, 0, 0, 0);
        car_entered = 1'b0; step(); exp_hex("full", SF, SU);

        // overflow attempt
        car_entered = 1'b1; step(); exp_st("ovf", 7'd0, 1, 0, 0, ERR_EN);
        car_entered = 1'b0; step(); exp_hex("ovf", SF, SU);
        err_clr = 1'b1; step(); exp_st("ovf_clr", 7'd0, 1, 0, 0, 0);
        err_clr = 1'b0; step();

        // simultaneous events at zero
        car_entered = 1'b1; car_exited = 1'b1; step(); exp_st("both", 7'd0, 1, 0, 0, 0);
        car_entered = 1'b0; car_exited = 1'b0; step(); exp_hex("both", SF, SU);

        // exit back to digits, then drain to capacity
        car_exited = 1'b1; step(); exp_st("exit1", 7'd1, 0, 0, 1, 0);
        car_exited = 1'b0; step(); exp_hex("exit1", BLANK, D1);
        repeat (6) exit_once();
        car_exited = 1'b1; step(); exp_st("empty", 7'd8, 0, 1, 1, 0);
        car_exited = 1'b0; step(); exp_hex("empty", BLANK, D8);

        // underflow attempt and error clear
        car_exited = 1'b1; step(); exp_st("unf", 7'd8, 0, 1, 1, ERR_EN);
        car_exited = 1'b0; step(); exp_hex("unf", ERR_EN ? SE : BLANK, D8);
        err_clr = 1'b1; step(); exp_st("unf_clr", 7'd8, 0, 1, 1, 0);
        err_clr = 1'b0; step(); exp_hex("unf_clr", BLANK, D8);

        // async reset mid-count at 3
        repeat (5) enter_once();
        exp_st("at3", 7'd3, 0, 0, 1, 0);
        step();
        #2;
        reset = 1'b0;
        #1;
        exp_st("async_rst", 7'd8, 0, 1, 1, 0);
        exp_hex("async_rst", BLANK, D8);

        // input held through reset release counts on first edge
        car_entered = 1'b1;
        step(); step();
        reset = 1'b1;
        step(); exp_st("held_rst", 7'd7, 0, 0, 1, 0);
        car_entered = 1'b0; step(); exp_hex("held_rst", BLANK, D7);

        step(); step();
        while (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s.unchecked: expectation for cycle %0d never compared", x.tag, x.at_cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
